accumulate_unit: RTL

Datapath stage directly downstream of the calculator control FSM. It turns the FSM's toggle-encoded command lines (`update`, `show`, `store`, `reset`) into single-cycle events and keeps a saturating running total of operand values. It selects either the live operand or the total for display and converts that value to BCD with a multi-cycle shift-add-3 converter for the 7-segment driver.

---
 rtl/calc_pkg.sv | 15 +
 rtl/bin2bcd_seq.sv | 78 +++++++
 rtl/accumulate_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared constants and converter state encoding for the calculator datapath.
// The control FSM imports the same package.
package calc_pkg;

  localparam int W_DEF      = 8;
  localparam int TW_DEF     = 12;
  localparam int DIGITS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } conv_state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per clock.
// bcd_out is the digit vector produced by the current iteration; it is final when done is high.
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int TW     = TW_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [TW-1:0]         bin_in,
  input  logic                  abort,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  done
);

  localparam int CW = $clog2(TW + 1);

  conv_state_t              state, state_nxt;
  logic [CW-1:0]            cnt;
  logic [TW-1:0]            bin_sr;
  logic [4*DIGITS-1:0]      bcd_sr;
  logic [4*DIGITS-1:0]      bcd_adj;
  logic [4*DIGITS+TW-1:0]   step;
  logic                     last;

  function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    r = v;
    for (int d = 0; d < DIGITS; d++) begin
      if (v[4*d +: 4] >= 4'd5) r[4*d +: 4] = v[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    bcd_adj = add3(bcd_sr);
    step    = {bcd_adj, bin_sr} << 1;
    bcd_out = step[4*DIGITS+TW-1 : TW];
    last    = (cnt == CW'(TW - 1));
    busy    = (state != IDLE);
    done    = busy && last && !abort;
  end

  // LOAD performs the first iteration, so TW iterations end TW edges after LOAD entry
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (start) state_nxt = LOAD;
      LOAD, SHIFT: state_nxt = last ? IDLE : SHIFT;
      default:     state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == IDLE) ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      bcd_sr <= '0;
      if (start) bin_sr <= bin_in;
    end else begin
      bcd_sr <= bcd_out;
      bin_sr <= step[TW-1:0];
    end
  end

endmodule

// File: rtl/accumulate_unit.sv
// Turns toggle-encoded commands into events, keeps a saturating running total,
// and drives a BCD display of either the live operand or the total.
module accumulate_unit
  import calc_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int TW     = TW_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                update,
  input  logic                show,
  input  logic                store,
  input  logic                reset,
  input  logic [W-1:0]        operand,
  output logic [4*DIGITS-1:0] disp_bcd,
  output logic                disp_valid,
  output logic                show_total,
  output logic                overflow,
  output logic                busy
);

  logic            update_q, show_q, store_q, reset_q;
  logic            update_ev, show_ev, store_ev, reset_ev;
  logic [TW-1:0]   total, src, last_conv;
  logic [TW:0]     sum_sat;
  logic            start, done;
  logic [4*DIGITS-1:0] bcd_out;

  // Bit TW of the result flags saturation; the low TW bits are the clamped sum.
  function automatic logic [TW:0] sat_add(input logic [TW-1:0] a, input logic [W-1:0] b);
    logic [TW:0] s;
    s = {1'b0, a} + {{(TW+1-W){1'b0}}, b};
    if (s[TW]) s = {1'b1, {TW{1'b1}}};
    return s;
  endfunction

  always_comb begin
    update_ev  = update ^ update_q;
    show_ev    = show ^ show_q;
    store_ev   = store ^ store_q;
    reset_ev   = reset ^ reset_q;
    sum_sat    = sat_add(total, operand);
    src        = show_total ? total : TW'(operand);
    start      = !busy && (src != last_conv);
    disp_valid = !busy && (src == last_conv);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      update_q   <= 1'b0;
      show_q     <= 1'b0;
      store_q    <= 1'b0;
      reset_q    <= 1'b0;
      total      <= '0;
      overflow   <= 1'b0;
      show_total <= 1'b0;
      last_conv  <= '0;
      disp_bcd   <= '0;
    end else begin
      update_q <= update;
      show_q   <= show;
      store_q  <= store;
      reset_q  <= reset;
      if (reset_ev) begin
        total      <= '0;
        overflow   <= 1'b0;
        show_total <= 1'b0;
        last_conv  <= '0;
        disp_bcd   <= '0;
      end else begin
        if (store_ev) begin
          total <= TW'(operand);
        end else if (update_ev) begin
          total <= sum_sat[TW-1:0];
          if (sum_sat[TW]) overflow <= 1'b1;
        end
        if (show_ev) show_total <= ~show_total;
        if (start)   last_conv  <= src;
        if (done)    disp_bcd   <= bcd_out;
      end
    end
  end

  bin2bcd_seq #(
    .TW     (TW),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (src),
    .abort   (reset_ev),
    .busy    (busy),
    .bcd_out (bcd_out),
    .done    (done)
  );

endmodule
